// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the EX stage.
// Owns the architectural HI/LO registers, runs radix-2 shift-add MULT and
// restoring DIV over DATA_W cycles, serves MFHI/MFLO reads and raises a stall
// when a dependent or conflicting instruction reaches EX while busy.
module ex_muldiv_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [2:0]        md_op,
  input  logic              flush,
  input  logic              md_abort,
  input  logic [DATA_W-1:0] a_ex,
  input  logic [DATA_W-1:0] b_ex,
  input  logic [DATA_W-1:0] result_mem,
  input  logic [DATA_W-1:0] result_wb,
  input  logic [1:0]        sel_a,
  input  logic [1:0]        sel_b,
  output logic [DATA_W-1:0] mf_result,
  output logic              busy,
  output logic              stall,
  output logic              md_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MFHI  = 3'd5;
  localparam logic [2:0] OP_MFLO  = 3'd6;

  // Architectural and iteration state
  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_acc;   // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]   r_opb;   // multiplicand or divisor magnitude
  logic                r_sa;
  logic                r_sb;
  logic                r_div;
  logic                r_divz;  // divide by zero: r_acc already holds {dividend, all ones}
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic                r_done;

  logic [1:0]          w_state_nxt;
  logic [DATA_W-1:0]   w_fa;
  logic [DATA_W-1:0]   w_fb;
  logic                w_is_md;
  logic                w_is_stallop;
  logic                w_is_mf;
  logic                w_op_signed;
  logic                w_op_div;
  logic                w_sa;
  logic                w_sb;
  logic [DATA_W-1:0]   w_abs_a;
  logic [DATA_W-1:0]   w_abs_b;
  logic                w_divz;
  logic                w_start;

  logic [DATA_W:0]     w_mul_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  logic [DATA_W:0]     w_div_shift;
  logic [DATA_W:0]     w_div_diff;
  logic                w_div_ge;
  logic [DATA_W-1:0]   w_div_rem;
  logic [2*DATA_W-1:0] w_div_next;

  logic [2*DATA_W-1:0] w_prod_fix;
  logic [DATA_W-1:0]   w_quo;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_fix_hi;
  logic [DATA_W-1:0]   w_fix_lo;

  // Forwarding muxes for both operands
  always_comb begin
    w_fa = '0;
    unique case (sel_a)
      2'd0:    w_fa = a_ex;
      2'd1:    w_fa = result_mem;
      2'd2:    w_fa = result_wb;
      default: w_fa = '0;
    endcase
    w_fb = '0;
    unique case (sel_b)
      2'd0:    w_fb = b_ex;
      2'd1:    w_fb = result_mem;
      2'd2:    w_fb = result_wb;
      default: w_fb = '0;
    endcase
  end

  // Opcode decode, operand magnitudes and start qualification
  always_comb begin
    w_is_md      = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                   (md_op == OP_DIV)  || (md_op == OP_DIVU);
    w_is_mf      = (md_op == OP_MFHI) || (md_op == OP_MFLO);
    w_is_stallop = w_is_md || w_is_mf;
    w_op_signed  = (md_op == OP_MULT) || (md_op == OP_DIV);
    w_op_div     = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    w_sa         = w_op_signed & w_fa[DATA_W-1];
    w_sb         = w_op_signed & w_fb[DATA_W-1];
    w_abs_a      = w_sa ? (~w_fa + 1'b1) : w_fa;
    w_abs_b      = w_sb ? (~w_fb + 1'b1) : w_fb;
    w_divz       = w_op_div & (w_fb == '0);
    busy         = (r_state != ST_IDLE);
    stall        = in_valid & ~flush & busy & w_is_stallop;
    w_start      = in_valid & ~flush & w_is_md & ~stall;
  end

  // One shift-add or restoring-divide step on the accumulator
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    w_mul_next  = {w_mul_sum, r_acc[DATA_W-1:1]};
    w_div_shift = r_acc[2*DATA_W-1:DATA_W-1];
    w_div_diff  = w_div_shift - {1'b0, r_opb};
    w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    // Without a subtract the shifted remainder is below the divisor, so it fits DATA_W bits
    w_div_rem   = w_div_ge ? w_div_diff[DATA_W-1:0] : w_div_shift[DATA_W-1:0];
    w_div_next  = {w_div_rem, r_acc[DATA_W-2:0], w_div_ge};
  end

  // Sign fix-up of the finished magnitude result
  always_comb begin
    w_prod_fix = (r_sa ^ r_sb) ? (~r_acc + 1'b1) : r_acc;
    w_quo      = r_acc[DATA_W-1:0];
    w_rem      = r_acc[2*DATA_W-1:DATA_W];
    if (r_divz) begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end else if (r_div) begin
      w_fix_hi = r_sa ? (~w_rem + 1'b1) : w_rem;
      w_fix_lo = (r_sa ^ r_sb) ? (~w_quo + 1'b1) : w_quo;
    end else begin
      w_fix_hi = w_prod_fix[2*DATA_W-1:DATA_W];
      w_fix_lo = w_prod_fix[DATA_W-1:0];
    end
  end

  // FSM next state; abort returns to IDLE from BUSY or FIX
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = w_divz ? ST_FIX : ST_BUSY;
      end
      ST_BUSY: begin
        if (md_abort)                       w_state_nxt = ST_IDLE;
        else if (r_cnt == CNT_W'(1))        w_state_nxt = ST_FIX;
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch, iteration datapath and HI/LO write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_opb  <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_div  <= 1'b0;
      r_divz <= 1'b0;
      r_hi   <= '0;
      r_lo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_sa   <= w_sa;
            r_sb   <= w_sb;
            r_div  <= w_op_div;
            r_divz <= w_divz;
            r_opb  <= w_abs_b;
            r_cnt  <= w_divz ? '0 : CNT_W'(DATA_W);
            r_acc  <= w_divz ? {w_fa, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, w_abs_a};
          end
        end
        ST_BUSY: begin
          r_acc <= r_div ? w_div_next : w_mul_next;
          r_cnt <= md_abort ? '0 : (r_cnt - CNT_W'(1));
        end
        ST_FIX: begin
          if (!md_abort) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Completion pulse in the cycle after a committed FIX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_done <= 1'b0;
    else        r_done <= (r_state == ST_FIX) & ~md_abort;
  end

  // MFHI/MFLO read port, no bypass from FIX
  always_comb begin
    mf_result = '0;
    if (in_valid && w_is_mf && !busy) mf_result = (md_op == OP_MFHI) ? r_hi : r_lo;
    md_done = r_done;
  end

endmodule
